// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with configurable width and depth, plus a
// choice of registered or first-word-fall-through (FWFT) read mode.
//
// Ports:
//   clk, rst_        clock; asynchronous active-low reset
//   flush            synchronous clear of pointers, count and error flags
//   w_en, wr_data    write request and data
//   r_en             read request (pop)
//   rd_data,rd_valid read data and its qualifier
//   full, empty, almost_full, almost_empty   occupancy flags (from registered state)
//   count            occupancy, 0..DEPTH
//   overflow, underflow  sticky error flags, cleared by flush or reset
module param_sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic                    flush,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_bad_params
        $error("param_sync_fifo: illegal DEPTH/AFULL_THRESH/AEMPTY_THRESH");
    end

    // Pointers carry one extra wrap bit so all DEPTH entries are usable.
    logic [PW-1:0]         head, tail, cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  ovf, udf;
    logic                  wr_acc, rd_acc;

    assign full         = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign empty        = (head == tail);
    assign count        = cnt;
    assign almost_full  = (cnt >= AF_T);
    assign almost_empty = (cnt <= AE_T);
    assign overflow     = ovf;
    assign underflow    = udf;

    // Acceptance uses start-of-cycle flags only, so a pop never frees room
    // for a same-cycle push into a full FIFO (and vice versa when empty).
    assign wr_acc = w_en && !full  && !flush;
    assign rd_acc = r_en && !empty && !flush;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            if (wr_acc) tail <= tail + PW'(1);
            if (rd_acc) head <= head + PW'(1);
            if (wr_acc && !rd_acc)      cnt <= cnt + PW'(1);
            else if (rd_acc && !wr_acc) cnt <= cnt - PW'(1);
            if (w_en && full)  ovf <= 1'b1;
            if (r_en && empty) udf <= 1'b1;
        end
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[tail[AW-1:0]] <= wr_data;
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is always on the output; zeroed when nothing is valid.
        assign rd_data  = empty ? '0 : mem[head[AW-1:0]];
        assign rd_valid = !empty;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  rv_q;

        // rd_acc is already low during flush, which clears rv_q.
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= rd_acc;
                if (rd_acc) rd_q <= mem[head[AW-1:0]];
            end
        end

        assign rd_data  = rd_q;
        assign rd_valid = rv_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: one registered-read and one FWFT instance driven
// by the same stimulus and compared against a queue-based reference model,
// plus a table of explicit vectors and directed corner-case sequences.
module tb_param_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_ = 1'b1;
    logic          flush = 1'b0, w_en = 1'b0, r_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic          rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [CW-1:0] count0, count1;

    param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                      .AEMPTY_THRESH(AE), .FWFT(0)) dut (
        .clk(clk), .rst_(rst_), .flush(flush), .w_en(w_en), .wr_data(wr_data),
        .r_en(r_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0));

    param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                      .AEMPTY_THRESH(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_(rst_), .flush(flush), .w_en(w_en), .wr_data(wr_data),
        .r_en(r_en), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, registered-read output as
    // last-popped word plus a one-cycle valid.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_udf, m_rv;
    logic [DW-1:0] m_rd;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic model_step(bit w, bit r, bit fl, logic [DW-1:0] d);
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_rv = 0;
        if (fl) begin
            q.delete();
            m_ovf = 0; m_udf = 0;
        end else begin
            if (w && was_full)  m_ovf = 1;
            if (r && was_empty) m_udf = 1;
            if (r && !was_empty) begin
                m_rd = q.pop_front();
                m_rv = 1;
            end
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_all(string tag);
        int n;
        n = q.size();
        chk({tag, " count"},  32'(count0), n);
        chk({tag, " full"},   32'(full0),  32'(n == DEPTH));
        chk({tag, " empty"},  32'(empty0), 32'(n == 0));
        chk({tag, " afull"},  32'(af0),    32'(n >= AF));
        chk({tag, " aempty"}, 32'(ae0),    32'(n <= AE));
        chk({tag, " ovf"},    32'(ovf0),   32'(m_ovf));
        chk({tag, " udf"},    32'(udf0),   32'(m_udf));
        chk({tag, " rvalid"}, 32'(rd_valid0), 32'(m_rv));
        chk({tag, " rdata"},  32'(rd_data0),  32'(m_rd));
        chk({tag, " f_count"},  32'(count1),    n);
        chk({tag, " f_ovf"},    32'(ovf1),      32'(m_ovf));
        chk({tag, " f_udf"},    32'(udf1),      32'(m_udf));
        chk({tag, " f_rvalid"}, 32'(rd_valid1), 32'(n != 0));
        if (n != 0) chk({tag, " f_rdata"}, 32'(rd_data1), 32'(q[0]));
    endtask

    // Drive one cycle's inputs, clock, then check 1 time unit after the edge.
    task automatic cycle(bit w, bit r, bit fl, logic [DW-1:0] d, string tag);
        w_en = w; r_en = r; flush = fl; wr_data = d;
        @(posedge clk); #1;
        model_step(w, r, fl, d);
        w_en = 0; r_en = 0; flush = 0;
        check_all(tag);
    endtask

    typedef struct {
        bit            w, r, fl;
        logic [DW-1:0] d;
        int            cnt;
        bit            ovf, udf, rv;
        logic [DW-1:0] rdat;
    } vec_t;

    vec_t vt[10];

    initial begin
        int wr_n, rd_n;

        // Registered-read scenarios starting from a drained FIFO with both
        // error flags set and rd_data holding 0x0F.
        vt[0] = '{0,0,1, 8'h00, 0, 0,0,0, 8'h0F}; // flush clears flags, keeps rd_data
        vt[1] = '{1,1,0, 8'h11, 1, 0,1,0, 8'h0F}; // both at empty: write only, underflow
        vt[2] = '{1,0,0, 8'h22, 2, 0,1,0, 8'h0F};
        vt[3] = '{0,1,0, 8'h00, 1, 0,1,1, 8'h11};
        vt[4] = '{0,0,1, 8'h00, 0, 0,0,0, 8'h11};
        vt[5] = '{0,1,0, 8'h00, 0, 0,1,0, 8'h11}; // read on empty
        vt[6] = '{1,0,0, 8'h33, 1, 0,1,0, 8'h11};
        vt[7] = '{1,1,0, 8'h44, 1, 0,1,1, 8'h33}; // both accepted, count steady
        vt[8] = '{0,1,0, 8'h00, 0, 0,1,1, 8'h44};
        vt[9] = '{0,0,0, 8'h00, 0, 0,1,0, 8'h44}; // rd_data holds

        // Reset state
        #2 rst_ = 1'b0;
        #1 model_reset();
        check_all("reset");
        @(negedge clk) rst_ = 1'b1;

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(i), "fill");
        cycle(1, 0, 0, 8'hFF, "ovf");
        chk("ovf flag", 32'(ovf0), 1);
        chk("ovf count", 32'(count0), DEPTH);

        // Drain in order, then underflow
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 8'h00, "drain");
            chk("drain data", 32'(rd_data0), i);
            chk("drain valid", 32'(rd_valid0), 1);
        end
        chk("drain empty", 32'(empty0), 1);
        cycle(0, 1, 0, 8'h00, "udf");
        chk("udf flag", 32'(udf0), 1);
        chk("udf hold", 32'(rd_data0), 32'h0F);
        chk("udf valid", 32'(rd_valid0), 0);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].w, vt[i].r, vt[i].fl, vt[i].d, "vec");
            chk($sformatf("vec%0d count", i), 32'(count0), vt[i].cnt);
            chk($sformatf("vec%0d ovf", i), 32'(ovf0), 32'(vt[i].ovf));
            chk($sformatf("vec%0d udf", i), 32'(udf0), 32'(vt[i].udf));
            chk($sformatf("vec%0d rvalid", i), 32'(rd_valid0), 32'(vt[i].rv));
            chk($sformatf("vec%0d rdata", i), 32'(rd_data0), 32'(vt[i].rdat));
        end

        // FWFT: word written into empty FIFO visible next cycle without r_en
        cycle(1, 0, 0, 8'hA5, "fwft wr");
        chk("fwft valid", 32'(rd_valid1), 1);
        chk("fwft data", 32'(rd_data1), 32'hA5);
        cycle(0, 1, 0, 8'h00, "fwft rd");
        chk("fwft empty", 32'(empty1), 1);
        chk("fwft valid off", 32'(rd_valid1), 0);

        // Push+pop at full: pop accepted, push rejected
        cycle(0, 0, 1, 8'h00, "flush");
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(8'h40 + i), "refill");
        cycle(1, 1, 0, 8'hEE, "full both");
        chk("full both count", 32'(count0), DEPTH - 1);
        chk("full both ovf", 32'(ovf0), 1);
        chk("full both data", 32'(rd_data0), 32'h40);

        // Wrap-around with count oscillating 3..7
        cycle(0, 0, 1, 8'h00, "flush");
        wr_n = 0; rd_n = 0;
        for (int i = 0; i < 80; i++) begin
            bit do_w;
            if (q.size() <= 3)      do_w = 1;
            else if (q.size() >= 7) do_w = 0;
            else                    do_w = bit'($urandom_range(0, 1));
            cycle(do_w, !do_w, 0, 8'($urandom), "wrap");
            if (do_w) wr_n++; else rd_n++;
            chk("wrap balance", 32'(count0), wr_n - rd_n);
        end

        // Flush at count 9 with overflow set
        cycle(0, 0, 1, 8'h00, "flush");
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(i + 8'h80), "fill9");
        cycle(1, 0, 0, 8'h00, "ovf9");
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'h00, "rd9");
        chk("pre-flush count", 32'(count0), 9);
        chk("pre-flush ovf", 32'(ovf0), 1);
        cycle(0, 0, 1, 8'h00, "flush9");
        chk("flush count", 32'(count0), 0);
        chk("flush empty", 32'(empty0), 1);
        chk("flush ovf", 32'(ovf0), 0);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 75 : 25;
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp - 20,
                  $urandom_range(0, 63) == 0, 8'($urandom), "rand");
        end

        // Asynchronous reset between edges
        #3 rst_ = 1'b0;
        #1 model_reset();
        check_all("async rst");
        @(negedge clk) rst_ = 1'b1;
        cycle(1, 0, 0, 8'h5A, "resume");
        chk("resume count", 32'(count0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
